// File: rtl/core_cf_arbiter_pkg.sv
// Shared core package: control-flow arbiter state encoding, reset vector
// and the control-flow unit operation codes.
package core_cf_arbiter_pkg;

    // Arbiter states: boot fetch, waiting, execute redirect, trap redirect
    typedef enum logic [1:0] {
        CF_ARB_BOOT = 2'd0,
        CF_ARB_IDLE = 2'd1,
        CF_ARB_EX   = 2'd2,
        CF_ARB_TRAP = 2'd3
    } cf_arb_state_e;

    // First fetch address after reset
    localparam logic [63:0] CF_RESET_ADDR = 64'h0000_0000_8000_0000;

    // Control-flow unit operations decoded in execute
    typedef enum logic [2:0] {
        CFU_OP_NONE = 3'd0,
        CFU_OP_JAL  = 3'd1,
        CFU_OP_JALR = 3'd2,
        CFU_OP_BEQ  = 3'd3,
        CFU_OP_BNE  = 3'd4,
        CFU_OP_BLT  = 3'd5,
        CFU_OP_BGE  = 3'd6,
        CFU_OP_MRET = 3'd7
    } cfu_op_e;

endpackage

// File: rtl/core_cf_arbiter.sv
// Control-flow arbiter: merges boot, execute-stage and trap redirects into a
// single registered valid/target handshake towards fetch. Traps win over
// execute requests, are latched as pending until their redirect is taken,
// and squash the pipeline with a one-cycle flush pulse.
module core_cf_arbiter
    import core_cf_arbiter_pkg::*;
#(
    parameter int          XL         = 63,
    parameter logic [XL:0] RESET_ADDR = CF_RESET_ADDR[XL:0]
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          ex_cf_valid,
    input  logic [XL:0]   ex_cf_target,
    output logic          ex_cf_ack,
    input  logic          trap_req,
    input  logic [XL:0]   trap_target,
    output logic          pipe_flush,
    output logic          cf_valid,
    output logic [XL:0]   cf_target,
    input  logic          cf_ack,
    output logic [31:0]   cf_count
);

    cf_arb_state_e state_q, state_d;
    logic          pending_q;
    logic [XL:0]   trap_vec_q;
    logic          valid_q, valid_d;
    logic [XL:0]   target_q, target_d;
    logic          flush_q;
    logic [31:0]   count_q;
    logic          pending_clr;
    logic          ex_ack;

    // A new trap is only accepted when none is already outstanding
    logic          trap_take;
    logic          trap_any;
    logic [XL:0]   trap_dest;

    assign trap_take = trap_req && !pending_q;
    assign trap_any  = pending_q || trap_req;
    assign trap_dest = pending_q ? trap_vec_q : trap_target;

    // Next-state and redirect selection; outputs hold until fetch acks
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        target_d    = target_q;
        ex_ack      = 1'b0;
        pending_clr = 1'b0;
        case (state_q)
            CF_ARB_BOOT: begin
                if (cf_ack) begin
                    if (trap_any) begin
                        state_d  = CF_ARB_TRAP;
                        target_d = trap_dest;
                    end else begin
                        state_d = CF_ARB_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            CF_ARB_IDLE: begin
                if (trap_any) begin
                    state_d  = CF_ARB_TRAP;
                    valid_d  = 1'b1;
                    target_d = trap_dest;
                end else if (ex_cf_valid && !flush_q) begin
                    state_d  = CF_ARB_EX;
                    valid_d  = 1'b1;
                    target_d = ex_cf_target;
                end
            end
            CF_ARB_EX: begin
                if (cf_ack) begin
                    ex_ack = 1'b1;
                    if (trap_any) begin
                        state_d  = CF_ARB_TRAP;
                        target_d = trap_dest;
                    end else begin
                        state_d = CF_ARB_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            CF_ARB_TRAP: begin
                if (cf_ack) begin
                    state_d     = CF_ARB_IDLE;
                    valid_d     = 1'b0;
                    pending_clr = 1'b1;
                end
            end
            default: begin
                state_d  = CF_ARB_BOOT;
                valid_d  = 1'b1;
                target_d = RESET_ADDR;
            end
        endcase
    end

    // State and registered redirect outputs
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q  <= CF_ARB_BOOT;
            valid_q  <= 1'b1;
            target_q <= RESET_ADDR;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    // Pending trap flag and captured vector; a trap clears only when its redirect is taken
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            pending_q  <= 1'b0;
            trap_vec_q <= '0;
        end else if (pending_clr) begin
            pending_q <= 1'b0;
        end else if (trap_take) begin
            pending_q  <= 1'b1;
            trap_vec_q <= trap_target;
        end
    end

    // One-cycle flush pulse following each accepted trap
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= trap_take;
        end
    end

    // Completed redirect counter, wraps naturally
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            count_q <= '0;
        end else if (valid_q && cf_ack) begin
            count_q <= count_q + 32'd1;
        end
    end

    // A second trap while one is outstanding is dropped; flag it in simulation
    assert property (@(posedge g_clk) disable iff (g_reset) !(trap_req && pending_q));

    assign ex_cf_ack  = ex_ack;
    assign pipe_flush = flush_q;
    assign cf_valid   = valid_q;
    assign cf_target  = target_q;
    assign cf_count   = count_q;

endmodule

// File: tb/tb_core_cf_arbiter.sv
// Bench for core_cf_arbiter: per-cycle vector table plus hand-written reset,
// boot-trap and counter-wrap sequences; redirect targets tracked by a queue.
module tb_core_cf_arbiter;

    localparam logic [63:0] RA = 64'h0000_0000_8000_0000;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        ex_cf_valid = 1'b0;
    logic [63:0] ex_cf_target = '0;
    logic        ex_cf_ack;
    logic        trap_req = 1'b0;
    logic [63:0] trap_target = '0;
    logic        pipe_flush;
    logic        cf_valid;
    logic [63:0] cf_target;
    logic        cf_ack = 1'b0;
    logic [31:0] cf_count;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic        ex_v;
        logic [63:0] ex_t;
        logic        tr;
        logic [63:0] tt;
        logic        ack;
        logic        e_valid;
        logic [63:0] e_target;
        logic        e_exack;
        logic        e_flush;
        logic [31:0] e_count;
        logic        push;
        logic [63:0] push_val;
    } vec_t;

    vec_t vecs[20];

    core_cf_arbiter dut (
        .g_clk        (g_clk),
        .g_reset      (g_reset),
        .ex_cf_valid  (ex_cf_valid),
        .ex_cf_target (ex_cf_target),
        .ex_cf_ack    (ex_cf_ack),
        .trap_req     (trap_req),
        .trap_target  (trap_target),
        .pipe_flush   (pipe_flush),
        .cf_valid     (cf_valid),
        .cf_target    (cf_target),
        .cf_ack       (cf_ack),
        .cf_count     (cf_count)
    );

    // Free-running clock
    always #5 g_clk = ~g_clk;

    function automatic vec_t mk(input logic ex_v, input logic [63:0] ex_t,
                                input logic tr, input logic [63:0] tt, input logic ack,
                                input logic e_valid, input logic [63:0] e_target,
                                input logic e_exack, input logic e_flush,
                                input logic [31:0] e_count,
                                input logic push, input logic [63:0] push_val);
        vec_t v;
        v.ex_v = ex_v; v.ex_t = ex_t; v.tr = tr; v.tt = tt; v.ack = ack;
        v.e_valid = e_valid; v.e_target = e_target; v.e_exack = e_exack;
        v.e_flush = e_flush; v.e_count = e_count; v.push = push; v.push_val = push_val;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check outputs just after
    task automatic apply_stimulus(input vec_t v, input string tag);
        logic [63:0] exp_t;
        @(negedge g_clk);
        ex_cf_valid  = v.ex_v;
        ex_cf_target = v.ex_t;
        trap_req     = v.tr;
        trap_target  = v.tt;
        cf_ack       = v.ack;
        if (v.push) sb_q.push_back(v.push_val);
        #1;
        check_output({tag, " cf_valid"}, {63'd0, cf_valid}, {63'd0, v.e_valid});
        if (v.e_valid) check_output({tag, " cf_target"}, cf_target, v.e_target);
        check_output({tag, " ex_cf_ack"}, {63'd0, ex_cf_ack}, {63'd0, v.e_exack});
        check_output({tag, " pipe_flush"}, {63'd0, pipe_flush}, {63'd0, v.e_flush});
        check_output({tag, " cf_count"}, {32'd0, cf_count}, {32'd0, v.e_count});
        if (cf_valid && v.ack) begin
            if (sb_q.size() == 0) begin
                check_output({tag, " sb_unexpected_redirect"}, cf_target, 64'hDEAD);
            end else begin
                exp_t = sb_q.pop_front();
                check_output({tag, " sb_target"}, cf_target, exp_t);
            end
        end
    endtask

    // Assert reset (possibly mid-redirect), check the reset state, release
    task automatic do_reset(input string tag);
        @(negedge g_clk);
        g_reset = 1'b1;
        ex_cf_valid = 1'b0; ex_cf_target = '0;
        trap_req = 1'b0; trap_target = '0; cf_ack = 1'b0;
        #1;
        check_output({tag, " rst cf_valid"}, {63'd0, cf_valid}, 64'd1);
        check_output({tag, " rst cf_target"}, cf_target, RA);
        check_output({tag, " rst pipe_flush"}, {63'd0, pipe_flush}, 64'd0);
        check_output({tag, " rst ex_cf_ack"}, {63'd0, ex_cf_ack}, 64'd0);
        check_output({tag, " rst cf_count"}, {32'd0, cf_count}, 64'd0);
        sb_q.delete();
        sb_q.push_back(RA);
        repeat (2) @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 1, RA, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, RA, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, RA, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 1, RA, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 64'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h8000_0100);
        vecs[5]  = mk(1, 64'h8000_0100, 0, 0, 0, 1, 64'h8000_0100, 0, 0, 1, 0, 0);
        vecs[6]  = mk(1, 64'h8000_0100, 0, 0, 1, 1, 64'h8000_0100, 1, 0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        vecs[9]  = mk(1, 64'h8000_0200, 1, 64'h8000_0040, 0, 0, 0, 0, 0, 2, 1, 64'h8000_0040);
        vecs[10] = mk(1, 64'h8000_0200, 0, 0, 0, 1, 64'h8000_0040, 0, 1, 2, 0, 0);
        vecs[11] = mk(1, 64'h8000_0200, 0, 0, 0, 1, 64'h8000_0040, 0, 0, 2, 0, 0);
        vecs[12] = mk(1, 64'h8000_0200, 0, 0, 1, 1, 64'h8000_0040, 0, 0, 2, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        vecs[14] = mk(1, 64'h200, 0, 0, 0, 0, 0, 0, 0, 3, 1, 64'h200);
        vecs[15] = mk(1, 64'h200, 1, 64'h40, 0, 1, 64'h200, 0, 0, 3, 1, 64'h40);
        vecs[16] = mk(1, 64'h200, 0, 0, 1, 1, 64'h200, 1, 1, 3, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 1, 64'h40, 0, 0, 4, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 1, 1, 64'h40, 0, 0, 4, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);

        do_reset("init");
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a trap redirect is outstanding
        apply_stimulus(mk(0, 0, 1, 64'h8000_0040, 0, 0, 0, 0, 0, 5, 1, 64'h8000_0040), "rtrap0");
        apply_stimulus(mk(0, 0, 0, 0, 0, 1, 64'h8000_0040, 0, 1, 5, 0, 0), "rtrap1");
        do_reset("midtrap");
        apply_stimulus(mk(0, 0, 0, 0, 1, 1, RA, 0, 0, 0, 0, 0), "rboot0");
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rboot1");

        // Trap raised during boot goes straight to the trap redirect
        do_reset("boot");
        apply_stimulus(mk(0, 0, 1, 64'h8000_0300, 0, 1, RA, 0, 0, 0, 1, 64'h8000_0300), "btrap0");
        apply_stimulus(mk(0, 0, 0, 0, 1, 1, RA, 0, 1, 0, 0, 0), "btrap1");
        apply_stimulus(mk(0, 0, 0, 0, 0, 1, 64'h8000_0300, 0, 0, 1, 0, 0), "btrap2");
        apply_stimulus(mk(0, 0, 0, 0, 1, 1, 64'h8000_0300, 0, 0, 1, 0, 0), "btrap3");
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), "btrap4");

        // Counter wrap from all-ones
        @(negedge g_clk);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        apply_stimulus(mk(1, 64'h8000_0600, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 64'h8000_0600), "wrap0");
        apply_stimulus(mk(1, 64'h8000_0600, 0, 0, 1, 1, 64'h8000_0600, 1, 0, 32'hFFFF_FFFF, 0, 0), "wrap1");
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap2");

        check_output("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
